sk6805_rx: RTL and testbench
============================

SK6805_RX -- requirements
Module: sk6805_rx

Interface
REQ-001 Parameter COUNT, default 2: number of LEDs whose color data this block captures; NBYTES = COUNT*3 and NBITS = NBYTES*8.
REQ-002 Parameter T_GLITCH, default 4: high pulses shorter than this many clocks are ignored.
REQ-003 Parameter T_SPLIT, default 28: a high pulse of at least this many clocks decodes as '1'; a shorter accepted pulse decodes as '0'.
REQ-004 Parameter T_HIGH_MAX, default 60: a high pulse that reaches this length is a protocol error.
REQ-005 Parameter T_LATCH, default 4000: this many consecutive low clocks end a frame (80 us at 50 MHz).
REQ-006 Port i_clk, input, 1: the only clock, 50 MHz.
REQ-007 Port i_rst, input, 1: asynchronous, active-high reset.
REQ-008 Port i_sk, input, 1: asynchronous single-wire LED data line.
REQ-009 Port i_addr, input, 3: byte index for readback.
REQ-010 Port o_data, output, 8: committed byte at index i_addr, combinational; reads 0 when i_addr >= NBYTES.
REQ-011 Port o_frame, output, 1: one-cycle pulse when a complete frame is committed.
REQ-012 Port o_err, output, 1: one-cycle pulse on a short frame or a stuck-high line.
REQ-013 Port o_busy, output, 1: high while in state HIGH or LOW.
REQ-014 Port o_sk_out, output, 1: daisy-chain forward of the bits that follow this block's NBITS.

Function
REQ-015 i_sk shall pass through a 2-flop synchronizer; line_s is the second flop; edges are detected against a third, delayed copy.
REQ-016 The FSM states shall be SYNC, IDLE, HIGH and LOW; a single counter cnt is cleared on every state entry and on every line edge.
REQ-017 SYNC: each line_s low cycle increments cnt; line_s high clears cnt; on cnt == T_LATCH-1 with line_s low, go to IDLE.
REQ-018 IDLE: bit_cnt = 0; a rising edge goes to HIGH.
REQ-019 HIGH, on a falling edge with cnt < T_GLITCH: discard the pulse and return to LOW, or to IDLE if bit_cnt == 0.
REQ-020 HIGH, on a falling edge otherwise: bit = (cnt >= T_SPLIT); go to LOW.
REQ-021 HIGH, on cnt reaching T_HIGH_MAX: pulse o_err, clear bit_cnt and fwd_en, go to SYNC; committed data is unchanged.
REQ-022 Decoded bits shall be shifted into the staging buffer MSB first.
REQ-023 Each completed byte k (k-th byte received, 0-based) shall be written to staging[k] while bit_cnt < NBITS.
REQ-024 bit_cnt shall saturate at NBITS.
REQ-025 LOW: a rising edge goes to HIGH; cnt reaching T_LATCH-1 ends the frame and goes to IDLE.
REQ-026 At frame end with bit_cnt == NBITS: copy staging to the committed registers and pulse o_frame in the same cycle.
REQ-027 At frame end with bit_cnt < NBITS: pulse o_err and leave the committed registers unchanged.
REQ-028 fwd_en shall set in the cycle after the NBITS-th bit is decoded, and clear at frame end or on error.
REQ-029 o_sk_out shall equal fwd_en & line_s, registered; forwarding latency from i_sk is 3 clocks.
REQ-030 The first rising edge after fwd_en sets shall be forwarded whole; a partially high pulse shall never be forwarded.
REQ-031 If a frame end and a rising edge occur in the same cycle, the frame end takes priority and the edge is seen from IDLE.
REQ-032 Counters shall be sized to hold max(T_LATCH, T_HIGH_MAX) and NBITS without wrap.

Reset
REQ-033 While i_rst is high: state = SYNC, all counters = 0, staging and committed registers = 0, synchronizer flops = 0, and o_frame, o_err, o_busy, o_sk_out = 0.
REQ-034 Reset asserted mid-frame shall discard partial data.
REQ-035 After reset the block shall require T_LATCH low clocks before decoding any bit.

Verification
REQ-036 After reset with the line low for 4000 clocks, send bytes A5 3C FF 00 81 7E (one bit = high 40 / low 24 clocks, zero bit = high 15 / low 49 clocks), then 4000 low clocks -> one o_frame pulse; i_addr 0..5 read A5 3C FF 00 81 7E; i_addr 6 and 7 read 0; o_sk_out stays 0.
REQ-037 Insert a 2-clock high glitch between bits of the REQ-036 frame -> identical result and no o_err.
REQ-038 Send only 24 bits (byte 12 three times) then latch -> one o_err pulse and no o_frame; readback still shows the previous frame.
REQ-039 Send 72 bits whose final 24 bits are 0xC3_55_AA -> o_sk_out reproduces those 24 pulses with matching widths, delayed by 3 clocks; o_frame pulses; readback equals the first 48 bits.
REQ-040 Hold the line high for 100 clocks mid-frame -> o_err pulses at high clock 60; the block does not decode again until 4000 low clocks have passed.
REQ-041 Assert i_rst during byte 3 of a frame -> all outputs are 0; the next full frame decodes correctly only after a 4000-clock low period.

Source files
------------

// File: rtl/sk6805_rx.sv
// SK6805 single-wire LED data receiver with daisy-chain forwarding.
// Captures COUNT LEDs of GRB bytes, commits them on latch, forwards the rest.
module sk6805_rx #(
  parameter int COUNT      = 2,
  parameter int T_GLITCH   = 4,
  parameter int T_SPLIT    = 28,
  parameter int T_HIGH_MAX = 60,
  parameter int T_LATCH    = 4000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sk,
  input  logic [2:0] i_addr,
  output logic [7:0] o_data,
  output logic       o_frame,
  output logic       o_err,
  output logic       o_busy,
  output logic       o_sk_out
);
  localparam int NBYTES = COUNT * 3;
  localparam int NBITS  = NBYTES * 8;
  localparam int TMAX   = (T_LATCH > T_HIGH_MAX) ? T_LATCH : T_HIGH_MAX;
  localparam int CW     = $clog2(TMAX + 1);
  localparam int BW     = $clog2(NBITS + 1);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t state, nxt;

  logic s1, line_s, s3;
  logic rise, fall;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [6:0] sr;
  logic fwd_en;
  logic [7:0] stage [NBYTES];
  logic [7:0] comm  [NBYTES];

  logic cnt_clr, bit_ok, bit_val, frame_end, hi_err, full;

  assign rise = line_s & ~s3;
  assign fall = ~line_s & s3;
  assign full = (bit_cnt == BW'(NBITS));
  assign bit_val = (cnt >= CW'(T_SPLIT));
  assign o_busy = (state == HIGH) || (state == LOW);

  // Synchronizer plus delayed copy for edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1     <= 1'b0;
      line_s <= 1'b0;
      s3     <= 1'b0;
    end else begin
      s1     <= i_sk;
      line_s <= s1;
      s3     <= line_s;
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= SYNC;
    else       state <= nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    nxt       = state;
    cnt_clr   = 1'b0;
    bit_ok    = 1'b0;
    frame_end = 1'b0;
    hi_err    = 1'b0;
    unique case (state)
      SYNC: begin
        if (line_s) begin
          cnt_clr = 1'b1;
        end else if (cnt == CW'(T_LATCH - 1)) begin
          nxt     = IDLE;
          cnt_clr = 1'b1;
        end
      end
      IDLE: begin
        // Level check so an edge coinciding with frame end is not lost
        if (line_s) begin
          nxt     = HIGH;
          cnt_clr = 1'b1;
        end
      end
      HIGH: begin
        if (fall) begin
          cnt_clr = 1'b1;
          if (cnt < CW'(T_GLITCH)) begin
            nxt = (bit_cnt == '0) ? IDLE : LOW;
          end else begin
            bit_ok = 1'b1;
            nxt    = LOW;
          end
        end else if (cnt == CW'(T_HIGH_MAX - 1)) begin
          hi_err  = 1'b1;
          nxt     = SYNC;
          cnt_clr = 1'b1;
        end
      end
      LOW: begin
        if (cnt == CW'(T_LATCH - 1)) begin
          frame_end = 1'b1;
          nxt       = IDLE;
          cnt_clr   = 1'b1;
        end else if (rise) begin
          nxt     = HIGH;
          cnt_clr = 1'b1;
        end
      end
      default: nxt = SYNC;
    endcase
  end

  // Shared interval counter, saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt <= '0;
    else if (cnt_clr || rise || fall) cnt <= '0;
    else if (cnt != CW'(TMAX)) cnt <= cnt + 1'b1;
  end

  // Bit decode, staging, commit and status pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt <= '0;
      sr      <= '0;
      fwd_en  <= 1'b0;
      o_frame <= 1'b0;
      o_err   <= 1'b0;
      for (int i = 0; i < NBYTES; i++) begin
        stage[i] <= '0;
        comm[i]  <= '0;
      end
    end else begin
      o_frame <= 1'b0;
      o_err   <= 1'b0;
      if (state == IDLE) bit_cnt <= '0;
      if (bit_ok) begin
        sr <= {sr[5:0], bit_val};
        if (!full) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt[2:0] == 3'd7)
            stage[bit_cnt[BW-1:3]] <= {sr, bit_val};
          if (bit_cnt == BW'(NBITS - 1))
            fwd_en <= 1'b1;
        end
      end
      if (hi_err) begin
        bit_cnt <= '0;
        fwd_en  <= 1'b0;
        o_err   <= 1'b1;
      end
      if (frame_end) begin
        fwd_en <= 1'b0;
        if (full) begin
          o_frame <= 1'b1;
          for (int i = 0; i < NBYTES; i++)
            comm[i] <= stage[i];
        end else begin
          o_err <= 1'b1;
        end
      end
    end
  end

  // Registered daisy-chain output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_sk_out <= 1'b0;
    else       o_sk_out <= fwd_en & line_s;
  end

  // Combinational readback of committed bytes
  always_comb begin
    o_data = '0;
    if (int'(i_addr) < NBYTES) o_data = comm[i_addr];
  end

endmodule

// File: tb/tb_sk6805_rx.sv
// Directed/randomized bench for sk6805_rx.
// Reference model tracks committed bytes and forwarded pulse shapes.
module tb_sk6805_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sk = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] data;
  logic frame, err, busy, sk_out;

  sk6805_rx dut (
    .i_clk(clk), .i_rst(rst), .i_sk(sk), .i_addr(addr),
    .o_data(data), .o_frame(frame), .o_err(err),
    .o_busy(busy), .o_sk_out(sk_out)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  int nframe = 0, nerr = 0, last_err_cyc = 0;
  int checks = 0, errors = 0;
  int in_rise[$], out_rise[$], out_w[$], exp_w[$];
  int run = 0;
  logic prev = 1'b0;
  logic [7:0] model [6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame) nframe <= nframe + 1;
    if (err) begin
      nerr <= nerr + 1;
      last_err_cyc <= cyc;
    end
    if (sk_out && !prev) out_rise.push_back(cyc);
    if (!sk_out && prev) out_w.push_back(run);
    run  <= sk_out ? run + 1 : 0;
    prev <= sk_out;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fwd);
    if (fwd) begin
      in_rise.push_back(cyc);
      exp_w.push_back(b ? 40 : 15);
    end
    sk = 1'b1;
    tick(b ? 40 : 15);
    sk = 1'b0;
    tick(b ? 24 : 49);
  endtask

  task automatic send_bits(input logic [71:0] v, input int n,
                           input int fwd_from, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      send_bit(v[n-1-i], i >= fwd_from);
      if (i == glitch_at) begin
        sk = 1'b1;
        tick(2);
        sk = 1'b0;
        tick(20);
      end
    end
  endtask

  task automatic set_model(input logic [47:0] v);
    for (int i = 0; i < 6; i++) model[i] = v[47-8*i -: 8];
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), int'(data),
            (a < 6) ? int'(model[a]) : 0);
    end
  endtask

  initial begin
    int f0, e0, c0;
    logic [47:0] r48;
    logic [71:0] v72;

    for (int i = 0; i < 6; i++) model[i] = '0;

    // reset state
    tick(3);
    check("rst_frame", int'(frame), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_skout", int'(sk_out), 0);
    readback("rst");
    rst = 1'b0;
    tick(4005);

    // basic frame
    f0 = nframe; e0 = nerr;
    send_bits({24'h0, 48'hA53CFF00817E}, 48, 99, -1);
    check("busy_after_frame_bits", int'(busy), 1);
    tick(4000);
    set_model(48'hA53CFF00817E);
    check("f1_frames", nframe - f0, 1);
    check("f1_errs", nerr - e0, 0);
    check("f1_noforward", out_rise.size(), 0);
    check("f1_idle", int'(busy), 0);
    readback("f1");

    // glitch between bits
    f0 = nframe; e0 = nerr;
    send_bits({24'h0, 48'hA53CFF00817E}, 48, 99, 20);
    tick(4000);
    check("gl_frames", nframe - f0, 1);
    check("gl_errs", nerr - e0, 0);
    readback("gl");

    // short frame
    f0 = nframe; e0 = nerr;
    send_bits({48'h0, 24'h121212}, 24, 99, -1);
    tick(4000);
    check("sh_frames", nframe - f0, 0);
    check("sh_errs", nerr - e0, 1);
    readback("sh");

    // 72 bits, last 24 forwarded
    in_rise.delete(); out_rise.delete(); out_w.delete(); exp_w.delete();
    r48 = {$urandom(), $urandom()};
    v72 = {r48, 24'hC355AA};
    f0 = nframe; e0 = nerr;
    send_bits(v72, 72, 48, -1);
    tick(4000);
    set_model(r48);
    check("fw_frames", nframe - f0, 1);
    check("fw_errs", nerr - e0, 0);
    check("fw_npulses", out_w.size(), 24);
    if (out_w.size() == 24 && out_rise.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        check($sformatf("fw_w%0d", i), out_w[i], exp_w[i]);
        check($sformatf("fw_lat%0d", i), out_rise[i] - in_rise[i], 3);
      end
    end
    readback("fw");

    // stuck high mid-frame
    f0 = nframe; e0 = nerr;
    send_bits({56'h0, 16'($urandom())}, 16, 99, -1);
    c0 = cyc;
    sk = 1'b1;
    tick(100);
    sk = 1'b0;
    tick(50);
    check("st_errs", nerr - e0, 1);
    check("st_err_time_lo", int'((last_err_cyc - c0) >= 60), 1);
    check("st_err_time_hi", int'((last_err_cyc - c0) <= 64), 1);
    check("st_not_busy", int'(busy), 0);
    send_bits({64'h0, 8'($urandom())}, 8, 99, -1);
    tick(100);
    check("st_ignored_busy", int'(busy), 0);
    tick(4000);
    check("st_ignored_errs", nerr - e0, 1);
    check("st_ignored_frames", nframe - f0, 0);
    readback("st_keep");
    r48 = {$urandom(), $urandom()};
    send_bits({24'h0, r48}, 48, 99, -1);
    tick(4000);
    set_model(r48);
    check("st_recover_frames", nframe - f0, 1);
    check("st_recover_errs", nerr - e0, 1);
    readback("st");

    // reset during byte 3
    r48 = {$urandom(), $urandom()};
    send_bits({24'h0, r48}, 20, 99, -1);
    rst = 1'b1;
    tick(2);
    for (int i = 0; i < 6; i++) model[i] = '0;
    check("mr_frame", int'(frame), 0);
    check("mr_err", int'(err), 0);
    check("mr_busy", int'(busy), 0);
    check("mr_skout", int'(sk_out), 0);
    readback("mr");
    rst = 1'b0;
    f0 = nframe; e0 = nerr;
    send_bits({64'h0, 8'hFF}, 8, 99, -1);
    tick(4000);
    check("mr_nodecode_errs", nerr - e0, 0);
    check("mr_nodecode_frames", nframe - f0, 0);
    r48 = {$urandom(), $urandom()};
    send_bits({24'h0, r48}, 48, 99, -1);
    tick(4000);
    set_model(r48);
    check("mr_frames", nframe - f0, 1);
    check("mr_errs", nerr - e0, 0);
    readback("mr_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
